// File: rtl/ps2_packet_framer.sv
// ---------------------------------------------------------------------------
// ps2_packet_framer
//
// Aligns a PS/2 mouse byte stream into packets. A byte whose SYNC_BIT is set
// starts a packet; ext_mode, sampled on that header byte, selects a
// BYTES_STD- or BYTES_EXT-byte packet. A packet that stalls for TIMEOUT_CYC
// cycles without a new byte is dropped (TIMEOUT_CYC=0 disables this).
//
// Optional build macro: PS2_FRAMER_STATS_EN adds the saturating discard
// counter output o_discard_cnt (bytes dropped while seeking a header, plus
// packets aborted by timeout).
//
// Ports:
//   i_clk          clock, everything synchronous to its rising edge
//   i_reset        synchronous, active-high reset
//   i_in           received byte
//   i_in_valid     i_in carries a new byte this cycle
//   i_ext_mode     1: BYTES_EXT-byte packets, 0: BYTES_STD-byte packets
//   o_out_bytes    last completed packet, first byte in the MS position,
//                  short packets right-aligned with zero upper bytes
//   o_done         one-cycle pulse, o_out_bytes just updated
//   o_timeout_err  one-cycle pulse, a partial packet was aborted
//   o_discard_cnt  discard statistics (PS2_FRAMER_STATS_EN only)
// ---------------------------------------------------------------------------
module ps2_packet_framer #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_BIT    = 3,
   parameter int unsigned BYTES_STD   = 3,
   parameter int unsigned BYTES_EXT   = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
`ifdef PS2_FRAMER_STATS_EN
   ,
   parameter int unsigned CNT_W       = 16
`endif
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [DATA_W-1:0]             i_in,
   input  logic                          i_in_valid,
   input  logic                          i_ext_mode,
   output logic [BYTES_EXT*DATA_W-1:0]   o_out_bytes,
   output logic                          o_done,
   output logic                          o_timeout_err
`ifdef PS2_FRAMER_STATS_EN
   ,
   output logic [CNT_W-1:0]              o_discard_cnt
`endif
);

   localparam int unsigned IDX_W = $clog2(BYTES_EXT);
   localparam int unsigned GAP_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int unsigned SH_W  = (BYTES_EXT - 1) * DATA_W;
   localparam int unsigned OUT_W = BYTES_EXT * DATA_W;

   localparam logic [IDX_W-1:0] LAST_STD = IDX_W'(BYTES_STD - 1);
   localparam logic [IDX_W-1:0] LAST_EXT = IDX_W'(BYTES_EXT - 1);
   localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(TIMEOUT_CYC);

   typedef enum logic {
      SEEK    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_n;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_n;
   logic                 r_len_sel;
   logic                 w_len_sel_n;
   logic [GAP_W-1:0]     r_gap;
   logic [GAP_W-1:0]     w_gap_n;
   logic [GAP_W-1:0]     w_gap_inc;
   logic [SH_W-1:0]      r_shift;
   logic [SH_W-1:0]      w_shift_n;
   logic [OUT_W-1:0]     r_out_bytes;
   logic [OUT_W-1:0]     w_out_n;
   logic                 r_done;
   logic                 w_done_n;
   logic                 r_timeout_err;
   logic                 w_timeout_err_n;
   logic [IDX_W-1:0]     w_last_idx;
   logic                 w_drop;
   logic                 w_abort;

   // Bytes are shifted in from the right and the register is cleared on the
   // header, so after L bytes the packet is already right-aligned with zero
   // upper bytes for any packet length; no per-index byte steering needed.
   always_comb begin
      w_state_n       = r_state;
      w_idx_n         = r_idx;
      w_len_sel_n     = r_len_sel;
      w_gap_n         = r_gap;
      w_shift_n       = r_shift;
      w_out_n         = r_out_bytes;
      w_done_n        = 1'b0;
      w_timeout_err_n = 1'b0;
      w_drop          = 1'b0;
      w_abort         = 1'b0;
      w_gap_inc       = r_gap + GAP_W'(1);
      w_last_idx      = r_len_sel ? LAST_EXT : LAST_STD;

      case (r_state)
         SEEK: begin
            w_gap_n = '0;
            w_idx_n = '0;
            if (i_in_valid) begin
               if (i_in[SYNC_BIT]) begin
                  w_shift_n   = SH_W'(i_in);
                  w_len_sel_n = i_ext_mode;
                  w_idx_n     = IDX_W'(1);
                  w_state_n   = COLLECT;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end

         COLLECT: begin
            if (i_in_valid) begin
               w_gap_n = '0;
               if (r_idx == w_last_idx) begin
                  w_out_n   = {r_shift, i_in};
                  w_done_n  = 1'b1;
                  w_idx_n   = '0;
                  w_state_n = SEEK;
               end else begin
                  w_shift_n = (r_shift << DATA_W) | SH_W'(i_in);
                  w_idx_n   = r_idx + IDX_W'(1);
               end
            end else if (TIMEOUT_CYC != 0) begin
               // Abort on the idle cycle that would bring the gap to the limit.
               if (w_gap_inc == GAP_LIM) begin
                  w_abort         = 1'b1;
                  w_timeout_err_n = 1'b1;
                  w_gap_n         = '0;
                  w_idx_n         = '0;
                  w_state_n       = SEEK;
               end else begin
                  w_gap_n = w_gap_inc;
               end
            end
         end

         default: begin
            w_state_n = SEEK;
            w_idx_n   = '0;
            w_gap_n   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= SEEK;
         r_idx         <= '0;
         r_len_sel     <= 1'b0;
         r_gap         <= '0;
         r_shift       <= '0;
         r_out_bytes   <= '0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_idx         <= w_idx_n;
         r_len_sel     <= w_len_sel_n;
         r_gap         <= w_gap_n;
         r_shift       <= w_shift_n;
         r_out_bytes   <= w_out_n;
         r_done        <= w_done_n;
         r_timeout_err <= w_timeout_err_n;
      end
   end

   assign o_out_bytes   = r_out_bytes;
   assign o_done        = r_done;
   assign o_timeout_err = r_timeout_err;

`ifdef PS2_FRAMER_STATS_EN
   logic [CNT_W-1:0] r_discard_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_discard_cnt <= '0;
      end else if ((w_drop || w_abort) && (r_discard_cnt != '1)) begin
         r_discard_cnt <= r_discard_cnt + CNT_W'(1);
      end
   end

   assign o_discard_cnt = r_discard_cnt;
`else
   // Drop/abort strobes only feed the statistics counter.
   logic w_unused_stats;
   assign w_unused_stats = w_drop | w_abort;
`endif

endmodule

// File: tb/tb_ps2_packet_framer.sv
// ---------------------------------------------------------------------------
// tb_ps2_packet_framer
//
// Directed bench for ps2_packet_framer (default build, TIMEOUT_CYC=4).
// Each table row gives the inputs applied for one clock cycle and the
// registered outputs expected just after that clock edge.
// ---------------------------------------------------------------------------
module tb_ps2_packet_framer;

   logic        clk;
   logic        reset;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        ext_mode;
   logic [31:0] out_bytes;
   logic        done;
   logic        timeout_err;

   ps2_packet_framer #(
      .DATA_W      (8),
      .SYNC_BIT    (3),
      .BYTES_STD   (3),
      .BYTES_EXT   (4),
      .TIMEOUT_CYC (4)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_in          (in_byte),
      .i_in_valid    (in_valid),
      .i_ext_mode    (ext_mode),
      .o_out_bytes   (out_bytes),
      .o_done        (done),
      .o_timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic        ext;
      logic [7:0]  d;
      logic        e_done;
      logic        e_terr;
      logic [31:0] e_out;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input logic rst, input logic vld, input logic ext,
                      input logic [7:0] d, input logic ed, input logic et,
                      input logic [31:0] eo);
      vec_t v;
      v.rst = rst; v.vld = vld; v.ext = ext; v.d = d;
      v.e_done = ed; v.e_terr = et; v.e_out = eo;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, sample outputs just after the rise.
   task automatic cycle(input logic rst, input logic vld, input logic ext, input logic [7:0] d);
      @(negedge clk);
      reset    = rst;
      in_valid = vld;
      ext_mode = ext;
      in_byte  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic ed, input logic et, input logic [31:0] eo);
      chk({tag, " done"}, {31'b0, done}, {31'b0, ed});
      chk({tag, " timeout_err"}, {31'b0, timeout_err}, {31'b0, et});
      chk({tag, " out_bytes"}, out_bytes, eo);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      ext_mode = 1'b0;
      in_byte  = 8'h00;

      // reset state
      add(1, 0, 0, 8'h00, 0, 0, 32'h0);
      add(1, 0, 0, 8'h00, 0, 0, 32'h0);
      // 3-byte packet
      add(0, 1, 0, 8'h08, 0, 0, 32'h0);
      add(0, 1, 0, 8'h12, 0, 0, 32'h0);
      add(0, 1, 0, 8'h34, 1, 0, 32'h00081234);
      // 4-byte packet, header in the done cycle, ext_mode dropped after header
      add(0, 1, 1, 8'h2C, 0, 0, 32'h00081234);
      add(0, 1, 0, 8'h01, 0, 0, 32'h00081234);
      add(0, 1, 0, 8'h02, 0, 0, 32'h00081234);
      add(0, 1, 0, 8'hFF, 1, 0, 32'h2C0102FF);
      // bytes without sync bit are dropped while seeking
      add(0, 1, 0, 8'h00, 0, 0, 32'h2C0102FF);
      add(0, 1, 0, 8'h07, 0, 0, 32'h2C0102FF);
      add(0, 1, 0, 8'h09, 0, 0, 32'h2C0102FF);
      add(0, 1, 0, 8'hAA, 0, 0, 32'h2C0102FF);
      add(0, 1, 0, 8'hBB, 1, 0, 32'h0009AABB);
      // timeout after 4 idle cycles inside a packet
      add(0, 0, 0, 8'h00, 0, 0, 32'h0009AABB);
      add(0, 1, 0, 8'h08, 0, 0, 32'h0009AABB);
      add(0, 1, 0, 8'h11, 0, 0, 32'h0009AABB);
      add(0, 0, 0, 8'h00, 0, 0, 32'h0009AABB);
      add(0, 0, 0, 8'h00, 0, 0, 32'h0009AABB);
      add(0, 0, 0, 8'h00, 0, 0, 32'h0009AABB);
      add(0, 0, 0, 8'h00, 0, 1, 32'h0009AABB);
      add(0, 1, 0, 8'h08, 0, 0, 32'h0009AABB);
      add(0, 1, 0, 8'h22, 0, 0, 32'h0009AABB);
      add(0, 1, 0, 8'h33, 1, 0, 32'h00082233);
      // back-to-back packets, pulses 3 cycles apart
      add(0, 1, 0, 8'h08, 0, 0, 32'h00082233);
      add(0, 1, 0, 8'h01, 0, 0, 32'h00082233);
      add(0, 1, 0, 8'h02, 1, 0, 32'h00080102);
      add(0, 1, 0, 8'h0A, 0, 0, 32'h00080102);
      add(0, 1, 0, 8'h03, 0, 0, 32'h00080102);
      add(0, 1, 0, 8'h04, 1, 0, 32'h000A0304);
      // reset mid-packet, then a fresh packet
      add(0, 1, 0, 8'h08, 0, 0, 32'h000A0304);
      add(0, 1, 0, 8'h55, 0, 0, 32'h000A0304);
      add(1, 0, 0, 8'h00, 0, 0, 32'h0);
      add(1, 1, 0, 8'h08, 0, 0, 32'h0);
      add(0, 1, 0, 8'h08, 0, 0, 32'h0);
      add(0, 1, 0, 8'h66, 0, 0, 32'h0);
      add(0, 1, 0, 8'h77, 1, 0, 32'h00086677);
      add(0, 0, 0, 8'h00, 0, 0, 32'h00086677);

      for (int i = 0; i < vq.size(); i++) begin
         cycle(vq[i].rst, vq[i].vld, vq[i].ext, vq[i].d);
         chk_out($sformatf("vec%0d", i), vq[i].e_done, vq[i].e_terr, vq[i].e_out);
      end

      // A byte arriving on the cycle the gap would hit the limit wins.
      cycle(0, 1, 0, 8'h08);
      chk_out("win hdr", 0, 0, 32'h00086677);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 8'h00);
         chk_out($sformatf("win idleA%0d", k), 0, 0, 32'h00086677);
      end
      cycle(0, 1, 0, 8'h11);
      chk_out("win byte1", 0, 0, 32'h00086677);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 8'h00);
         chk_out($sformatf("win idleB%0d", k), 0, 0, 32'h00086677);
      end
      cycle(0, 1, 0, 8'h22);
      chk_out("win last", 1, 0, 32'h00081122);
      cycle(0, 0, 0, 8'h00);
      chk_out("win after", 0, 0, 32'h00081122);

      // Idle time while seeking never produces a timeout.
      for (int k = 0; k < 6; k++) begin
         cycle(0, 0, 1, 8'h00);
         chk_out($sformatf("seek idle%0d", k), 0, 0, 32'h00081122);
      end

      // Extended packet whose header carries ext_mode=1, then timeout at byte 3.
      cycle(0, 1, 1, 8'hF8);
      cycle(0, 1, 0, 8'hA1);
      cycle(0, 1, 0, 8'hA2);
      chk_out("ext partial", 0, 0, 32'h00081122);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 8'h00);
      chk_out("ext gap3", 0, 0, 32'h00081122);
      cycle(0, 0, 0, 8'h00);
      chk_out("ext timeout", 0, 1, 32'h00081122);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_packet_framer.md
Name: ps2_packet_framer

Overview:
Parametrised PS/2 mouse packet framer. It accepts a byte stream qualified by a valid strobe and aligns packets on a sync bit in the header byte. It supports a standard 3-byte and an extended (IntelliMouse-style) 4-byte packet length, and discards stalled partial packets after a configurable inter-byte timeout. It sits between the PS/2 byte receiver and the mouse-event decoder.

Parameters:
DATA_W, 8, width of one received byte
SYNC_BIT, 3, bit index in the header byte that must be 1 for the byte to be accepted as a header (0..DATA_W-1)
BYTES_STD, 3, packet length in bytes when ext_mode=0 (2..BYTES_EXT)
BYTES_EXT, 4, packet length in bytes when ext_mode=1 (BYTES_STD..8)
TIMEOUT_CYC, 1024, maximum cycles without in_valid inside a packet before the packet is aborted; 0 disables the timeout
CNT_W, 16, width of the statistics counter (optional feature only)

Ports:
clk  in  1  clock; everything is synchronous to posedge clk
reset  in  1  synchronous, active-high reset
in  in  DATA_W  received byte
in_valid  in  1  in carries a new byte this cycle
ext_mode  in  1  1 selects BYTES_EXT packets, 0 selects BYTES_STD packets
out_bytes  out  BYTES_EXT*DATA_W  last completed packet, first byte in the MS position
done  out  1  one-cycle pulse: a packet completed and out_bytes was updated
timeout_err  out  1  one-cycle pulse: a partial packet was aborted by timeout
discard_cnt  out  CNT_W  present only with PS2_FRAMER_STATS_EN

Behaviour:
- Reset values: state=SEEK, byte index=0, gap counter=0, out_bytes=0, done=0, timeout_err=0, discard_cnt=0.
- All outputs are registered.
- Bytes are processed only in cycles where in_valid=1. in is don't-care when in_valid=0.
- State SEEK:
  - in_valid & in[SYNC_BIT] → accept the byte as byte 0, latch ext_mode into len_sel, idx=1, go to COLLECT.
  - in_valid & !in[SYNC_BIT] → drop the byte, stay in SEEK.
- State COLLECT:
  - in_valid → store the byte at idx and increment idx.
  - When the byte at idx = L-1 is stored (L = BYTES_EXT if len_sel else BYTES_STD), in the same edge:
    - out_bytes ← the assembled packet;
    - done ← 1 for the next cycle;
    - state ← SEEK.
  - Sync bit is not checked on non-header bytes.
- Packet packing:
  - 4-byte packet: out_bytes = {b0,b1,b2,b3}.
  - Short packet (L < BYTES_EXT): out_bytes = {b0..b(L-1)} right-aligned, upper bits zero. With defaults: out_bytes = {8'h00,b0,b1,b2}.
  - out_bytes holds its value until the next completed packet; it never goes X.
- Latency: done and the new out_bytes are visible the cycle after the edge that samples the last byte.
- Back-to-back packets: a header byte arriving in the cycle done=1 is accepted. No bubble is required.
- ext_mode changes mid-packet have no effect on that packet; ext_mode is sampled only at header acceptance.
- Timeout (TIMEOUT_CYC>0):
  - The gap counter clears on every accepted byte and increments each COLLECT cycle with in_valid=0.
  - When it reaches TIMEOUT_CYC, in that cycle:
    - state ← SEEK, idx ← 0;
    - the partial packet is discarded and out_bytes is unchanged;
    - timeout_err pulses for 1 cycle.
  - If in_valid=1 in the cycle the counter would reach TIMEOUT_CYC, the byte wins and no timeout occurs.
- Reset asserted mid-packet: the packet is discarded; no done and no timeout_err pulse.
- done and timeout_err are never high in the same cycle.

Optional Feature:
PS2_FRAMER_STATS_EN
- Defined:
  - The discard_cnt output exists.
  - It increments by 1 for each byte dropped in SEEK, and by 1 for each packet aborted by timeout.
  - It saturates at 2^CNT_W-1 and clears only on reset.
- Undefined: the port and all counter logic are absent. Framing behaviour is identical in both builds.

Test Plan:
- Defaults, ext_mode=0, bytes 0x08,0x12,0x34 on consecutive cycles → done=1 one cycle after 0x34 is sampled; out_bytes=0x00081234.
- ext_mode=1, bytes 0x2C,0x01,0x02,0xFF → out_bytes=0x2C0102FF with one done pulse; ext_mode dropped to 0 after the header → still 4 bytes framed.
- Leading bytes 0x00,0x07 (bit3=0), then 0x09,0xAA,0xBB → first two dropped; out_bytes=0x0009AABB; with STATS_EN, discard_cnt=2.
- TIMEOUT_CYC=4: header 0x08, byte 0x11, then 4 idle cycles → timeout_err pulse, no done, out_bytes unchanged; the next 0x08,0x22,0x33 frames to 0x00082233.
- Two packets back-to-back, with the second header arriving in the done cycle → two done pulses 3 cycles apart; both out_bytes values correct.
- Reset asserted after 2 bytes of a packet, then 3 new bytes → no pulse during reset; outputs return to 0; the new packet frames correctly.
